spi_xfer_responder: RTL
=======================

SPI_XFER_RESPONDER -- requirements
Module: spi_xfer_responder

Interface
REQ-001 SHALL have parameter DATA_W, 8, transfer width in bits (legal range 2..32).
REQ-002 SHALL have parameter CLK_DIV, 2, number of spi_clk cycles per sclk half-period (legal range 1..255).
REQ-003 SHALL have port spi_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port preset  input  1  synchronous, active-high reset, sampled on the rising edge of spi_clk.
REQ-005 SHALL have port spi_enable  input  1  request level from the synchronizer; already in the spi_clk domain.
REQ-006 SHALL have port tx_data  input  DATA_W  word to transmit; stable while spi_enable=1.
REQ-007 SHALL have port pready  output  1  acknowledge level returned to the requester (4-phase handshake).
REQ-008 SHALL have port rx_data  output  DATA_W  last received word; valid while pready=1.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port sclk  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-011 SHALL have port ss_n  output  1  active-low slave select.
REQ-012 SHALL have port mosi  output  1  serial data out, MSB first.
REQ-013 SHALL have port miso  input  1  serial data in, MSB first.

Function
REQ-014 SHALL implement the FSM states IDLE, LEAD, SHIFT, TRAIL and ACK, with all outputs driven from registers.
REQ-015 IDLE: if spi_enable=1 and pready=0 at edge E0, SHALL load tx_data into the TX shift register, clear the counters, set ss_n=0 and enter LEAD.
REQ-016 LEAD: SHALL hold sclk=0 and drive mosi=TX[DATA_W-1] for CLK_DIV cycles, then enter SHIFT at E0+CLK_DIV.
REQ-017 SHIFT: SHALL use a divider counter of 0..CLK_DIV-1 and toggle sclk at terminal count; the first toggle (rising) occurs CLK_DIV cycles after SHIFT entry.
REQ-018 On each sclk 0->1 update, SHALL shift the sampled miso value into the RX shift register LSB.
REQ-019 On each sclk 1->0 update, SHALL shift TX left by one, present the new MSB on mosi, and increment the bit counter.
REQ-020 After the DATA_W-th falling sclk edge, SHALL enter TRAIL with sclk=0.
REQ-021 TRAIL: SHALL wait CLK_DIV cycles; on exit, in the same edge, SHALL set ss_n=1, rx_data=RX and pready=1, and enter ACK.
REQ-022 Latency: pready SHALL rise exactly at E0+CLK_DIV*(2*DATA_W+2).
REQ-023 ACK: SHALL hold pready=1 and rx_data stable until spi_enable=0 is sampled, then set pready=0 and enter IDLE on that edge.
REQ-024 A new transfer SHALL NOT start until pready=0 and spi_enable=1 are both sampled; a back-to-back request therefore needs spi_enable low for at least one cycle.
REQ-025 Changes of spi_enable or tx_data during LEAD, SHIFT or TRAIL SHALL be ignored; the transfer completes with the captured word.
REQ-026 If spi_enable is already 0 on ACK entry, pready SHALL be high for exactly one cycle.
REQ-027 rx_data SHALL change only on TRAIL exit; otherwise it holds its previous value.
REQ-028 mosi SHALL be 0 in IDLE and ACK.

Reset
REQ-029 While preset=1 at an edge, SHALL force state=IDLE, pready=0, busy=0, sclk=0, ss_n=1, mosi=0, rx_data=0 and all counters and shift registers to 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer at that edge, with no pready pulse and ss_n=1 on the next cycle.
REQ-031 After reset releases, SHALL start a transfer only on a sampled spi_enable=1.

Verification
REQ-032 DATA_W=8, CLK_DIV=2, tx_data=0xA5, miso model returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1 sampled on sclk rises; rx_data=0x3C; pready rises at E0+36; 8 sclk pulses.
REQ-033 Hold spi_enable=1 for 10 cycles after pready rises, then drop it -> pready stays 1 throughout, falls on the edge that samples spi_enable=0, busy=0 after that edge.
REQ-034 Back-to-back transfers 0xFF then 0x00 with spi_enable low for 1 cycle between -> second ss_n low starts one cycle after pready falls; rx_data=miso words in order.
REQ-035 Assert preset at cycle E0+15 mid-SHIFT -> next cycle ss_n=1, sclk=0, pready=0, rx_data=0; no pready pulse follows.
REQ-036 Pulse spi_enable for 1 cycle only, tx_data=0x81 -> full transfer completes; pready is high for exactly 1 cycle at E0+36.
REQ-037 CLK_DIV=1, DATA_W=4, tx_data=0x9 -> sclk toggles every cycle; pready rises at E0+10.

Source files
------------

// File: rtl/spi_xfer_responder.sv
// SPI mode-0 master driven by a 4-phase enable/pready handshake; one DATA_W-bit word per request.
// pready rises CLK_DIV*(2*DATA_W+2) cycles after the start edge and is held until spi_enable drops.
module spi_xfer_responder #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              spi_clk,
  input  logic              preset,
  input  logic              spi_enable,
  input  logic [DATA_W-1:0] tx_data,
  output logic              pready,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              pready_q, pready_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;

  logic              div_done;

  assign div_done = (div_q == DIV_LAST);

  always_ff @(posedge spi_clk) begin
    if (preset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      pready_q  <= 1'b0;
      busy_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      pready_q  <= pready_d;
      busy_q    <= busy_d;
      sclk_q    <= sclk_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    pready_d  = pready_q;
    sclk_d    = sclk_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        if (spi_enable && !pready_q) begin
          tx_d      = tx_data;
          rx_d      = '0;
          div_d     = '0;
          bit_cnt_d = '0;
          ss_n_d    = 1'b0;
          mosi_d    = tx_data[DATA_W-1];
          state_d   = LEAD;
        end
      end

      LEAD: begin
        if (div_done) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      SHIFT: begin
        if (div_done) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising sclk: capture the slave's bit.
            rx_d = {rx_q[DATA_W-2:0], miso};
          end else begin
            // Falling sclk: advance to the next outgoing bit.
            tx_d      = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d    = tx_q[DATA_W-2];
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = TRAIL;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      TRAIL: begin
        if (div_done) begin
          div_d     = '0;
          ss_n_d    = 1'b1;
          rx_data_d = rx_q;
          pready_d  = 1'b1;
          mosi_d    = 1'b0;
          state_d   = ACK;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      ACK: begin
        mosi_d = 1'b0;
        if (!spi_enable) begin
          pready_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        pready_d = 1'b0;
        sclk_d   = 1'b0;
        ss_n_d   = 1'b1;
        mosi_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign pready  = pready_q;
  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign sclk    = sclk_q;
  assign ss_n    = ss_n_q;
  assign mosi    = mosi_q;

endmodule
